// File: rtl/apb_multi_master_pkg.sv
// Shared types for apb_multi_master: FSM state encoding and APB field widths.
// Latency: n/a. Backpressure: n/a.
package apb_multi_master_pkg;

  localparam int PROT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_multi_master_if.sv
// Request/response channels plus the APB bus of apb_multi_master.
// Latency: n/a. Backpressure: valid/ready on req and rsp, pready on APB.
interface apb_multi_master_if #(
  parameter int DATASIZE   = 32,
  parameter int ADDRSIZE   = 32,
  parameter int NUM_SLAVES = 10
);
  import apb_multi_master_pkg::*;

  logic                           req_valid;
  logic                           req_ready;
  logic                           req_write;
  logic [ADDRSIZE-1:0]            req_addr;
  logic [DATASIZE-1:0]            req_wdata;
  logic [DATASIZE/8-1:0]          req_strb;
  logic [PROT_WIDTH-1:0]          req_prot;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [DATASIZE-1:0]            rsp_rdata;
  logic                           rsp_err;
  logic [NUM_SLAVES-1:0]          PSEL;
  logic                           PENABLE;
  logic [ADDRSIZE-1:0]            PADDR;
  logic [DATASIZE-1:0]            PWDATA;
  logic                           PWRITE;
  logic [PROT_WIDTH-1:0]          PPROT;
  logic [DATASIZE/8-1:0]          PSTRB;
  logic [NUM_SLAVES-1:0]          pready;
  logic [NUM_SLAVES-1:0]          pslverr;
  logic [NUM_SLAVES*DATASIZE-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
           pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PADDR, PWDATA, PWRITE, PPROT, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, rsp_ready,
           pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PADDR, PWDATA, PWRITE, PPROT, PSTRB
  );

endinterface

// File: rtl/apb_multi_master_decoder.sv
// Combinational APB slave decoder: slave-index field of the address to index, one-hot select and hit.
// Latency: 0 cycles. Backpressure: none.
module apb_slave_decoder #(
  parameter int ADDRSIZE   = 32,
  parameter int NUM_SLAVES = 10,
  parameter int SEL_LSB    = 12,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [ADDRSIZE-1:0]   addr,
  output logic [SEL_WIDTH-1:0]  idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  // Only the index field matters; the rest of the address is deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  assign idx = addr[SEL_LSB +: SEL_WIDTH];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (idx == SEL_WIDTH'(i));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_multi_master.sv
// APB master + slave select; ACCESS timeout abort only when APB_MASTER_TIMEOUT_EN is defined.
// Latency: rsp_valid 3 cycles after accept plus wait states; 1 cycle on a decode miss.
// Backpressure: one transfer in flight, req_ready only in IDLE; response held until rsp_ready.
module apb_multi_master
  import apb_multi_master_pkg::*;
#(
  parameter int DATASIZE       = 32,
  parameter int ADDRSIZE       = 32,
  parameter int NUM_SLAVES     = 10,
  parameter int SEL_LSB        = 12,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset,
  apb_multi_master_if.master bus
);

  localparam int STRB_W = DATASIZE / 8;

  if (NUM_SLAVES < 1 || NUM_SLAVES > (2 ** SEL_WIDTH) || TIMEOUT_CYCLES < 1 ||
      (DATASIZE % 8) != 0) begin : g_bad_cfg
    $error("apb_multi_master: illegal parameter combination");
  end

  apb_state_e            state_q, state_d;
  logic [ADDRSIZE-1:0]   addr_q, addr_d;
  logic [DATASIZE-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [PROT_WIDTH-1:0] prot_q, prot_d;
  logic                  write_q, write_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [DATASIZE-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [SEL_WIDTH-1:0]  dec_idx_unused;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;

  apb_slave_decoder #(
    .ADDRSIZE  (ADDRSIZE),
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_LSB   (SEL_LSB),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_dec (
    .addr(bus.req_addr),
    .idx (dec_idx_unused),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // Only the latched slave's ready/error/data are looked at.
  logic [DATASIZE-1:0] rd_mux;
  logic                ready_sel;
  logic                slverr_sel;

  always_comb begin
    rd_mux     = '0;
    ready_sel  = 1'b0;
    slverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        rd_mux     = bus.prdata[i*DATASIZE +: DATASIZE];
        ready_sel  = bus.pready[i];
        slverr_sel = bus.pslverr[i];
      end
    end
  end

  logic timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // cnt_inc equals the number of ACCESS cycles completed at the end of this cycle.
  always_comb begin
    cnt_inc     = cnt_q + CNT_W'(1);
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS) begin
      cnt_d       = cnt_inc;
      timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    write_d = write_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          strb_d  = bus.req_strb;
          prot_d  = bus.req_prot;
          write_d = bus.req_write;
          sel_d   = dec_sel;
          if (dec_hit) begin
            state_d = SETUP;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A ready arriving on the limit cycle wins over the abort.
        if (ready_sel) begin
          state_d = RESP;
          err_d   = slverr_sel;
          rdata_d = (write_q || slverr_sel) ? '0 : rd_mux;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.PWRITE    = write_q;
  assign bus.PPROT     = prot_q;
  assign bus.PSTRB     = write_q ? strb_q : '0;

endmodule
